// File: rtl/mux_select_sequencer.sv
// Round-robin select generator for a 4:1 mux: grants one requesting channel
// for DWELL cycles. Define MUX_SEQ_CAPTURE_EN to build the y_smp/smp_valid capture.
module mux_select_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    input  logic       y_in,
    output logic       s0,
    output logic       s1,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       y_smp,
    output logic       smp_valid
);

    // A dwell of 0 is treated as a single-cycle dwell.
    localparam int            DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(DWELL_EFF - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [1:0]    r_last, w_last_next;
    logic [1:0]    r_sel, w_sel_next;
    logic [3:0]    r_gnt, w_gnt_next;
    logic          r_busy, w_busy_next;

    logic [3:0]    w_req_rot;
    logic [1:0]    w_offset;
    logic [1:0]    w_winner;
    logic [3:0]    w_winner_oh;
    logic          w_start;
    logic          w_final;

    // Bit gi of w_req_rot is channel last+1+gi, so the previous winner sits at bit 3.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign w_req_rot[gi]   = req[2'(r_last + 2'(gi + 1))];
            assign w_winner_oh[gi] = (w_winner == 2'(gi));
        end
    endgenerate

    always_comb begin
        w_offset = 2'd3;
        if (w_req_rot[0])      w_offset = 2'd0;
        else if (w_req_rot[1]) w_offset = 2'd1;
        else if (w_req_rot[2]) w_offset = 2'd2;
    end

    assign w_winner = 2'(r_last + w_offset + 2'd1);
    assign w_start  = en & (|req);
    assign w_final  = (r_state == ST_HOLD) && (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 2'd3;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_last  <= w_last_next;
            r_sel   <= w_sel_next;
            r_gnt   <= w_gnt_next;
            r_busy  <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_last_next  = r_last;
        w_sel_next   = r_sel;
        w_gnt_next   = r_gnt;
        w_busy_next  = r_busy;
        case (r_state)
            ST_IDLE: begin
                w_gnt_next  = 4'b0000;
                w_busy_next = 1'b0;
                if (w_start) begin
                    w_state_next = ST_HOLD;
                    w_sel_next   = w_winner;
                    w_last_next  = w_winner;
                    w_gnt_next   = w_winner_oh;
                    w_cnt_next   = CNT_LOAD;
                    w_busy_next  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CW'(1);
                end else if (w_start) begin
                    // Back-to-back grant: no idle bubble between dwells.
                    w_sel_next  = w_winner;
                    w_last_next = w_winner;
                    w_gnt_next  = w_winner_oh;
                    w_cnt_next  = CNT_LOAD;
                    w_busy_next = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_gnt_next   = 4'b0000;
                    w_busy_next  = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_gnt_next   = 4'b0000;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign s1   = r_sel[1];
    assign s0   = r_sel[0];
    assign gnt  = r_gnt;
    assign busy = r_busy;

`ifdef MUX_SEQ_CAPTURE_EN
    logic r_y_smp;
    logic r_smp_valid;

    // y_in has been settling for the whole dwell by the final edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_smp     <= 1'b0;
            r_smp_valid <= 1'b0;
        end else begin
            r_smp_valid <= w_final;
            if (w_final) begin
                r_y_smp <= y_in;
            end
        end
    end

    assign y_smp     = r_y_smp;
    assign smp_valid = r_smp_valid;
`else
    logic w_unused_ok;

    assign w_unused_ok = y_in ^ w_final;
    assign y_smp       = 1'b0;
    assign smp_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Randomized self-checking bench for mux_select_sequencer against a
// dwell/round-robin reference model; includes a behavioural 4:1 mux on y_in.
module tb_mux_select_sequencer;

    localparam int DW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] mux_data = 4'b0000;
    logic       y_in;
    logic       s0, s1;
    logic [3:0] gnt;
    logic       busy, y_smp, smp_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: granted channel (-1 = none), cycles left in dwell.
    int m_ch, m_left, m_last, m_sel;
    int m_y, m_sv;

    always #5 clk = ~clk;

    assign y_in = mux_data[{s1, s0}];

    mux_select_sequencer #(.DWELL(DW), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .y_in(y_in),
        .s0(s0), .s1(s1), .gnt(gnt), .busy(busy),
        .y_smp(y_smp), .smp_valid(smp_valid)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ch = -1; m_left = 0; m_last = 3; m_sel = 0; m_y = 0; m_sv = 0;
    endfunction

    function automatic void model_edge();
        int c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_sv = 0;
        if (m_ch >= 0 && m_left > 1) begin
            m_left--;
            return;
        end
        if (m_ch >= 0) begin
`ifdef MUX_SEQ_CAPTURE_EN
            m_sv = 1;
            m_y  = int'(mux_data[m_sel]);
`endif
        end
        m_ch = -1;
        if (en && req != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last + k) % 4;
                if (req[c]) begin
                    m_ch = c; m_left = DW; m_last = c; m_sel = c;
                    break;
                end
            end
        end
    endfunction

    task automatic check_outputs(input string ph);
        int exp_gnt;
        exp_gnt = (m_ch < 0) ? 0 : (1 << m_ch);
        check_value({ph, ".sel"}, 32'({s1, s0}), 32'(m_sel));
        check_value({ph, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        check_value({ph, ".busy"}, 32'(busy), (m_ch >= 0) ? 32'd1 : 32'd0);
        check_value({ph, ".y_smp"}, 32'(y_smp), 32'(m_y));
        check_value({ph, ".smp_valid"}, 32'(smp_valid), 32'(m_sv));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(ph);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset held with requests pending.
        rst_n = 1'b0; en = 1'b1; req = 4'b1111; mux_data = 4'b0011;
        repeat (3) step("reset");
        #2 rst_n = 1'b1;

        // Full scan with capture pattern i0=1, i1=1, i2=0, i3=0.
        repeat (6 * DW) step("scan");

        // Sparse fairness: only ch0 and ch2 may ever be granted.
        req = 4'b0101;
        for (int i = 0; i < 5 * DW; i++) begin
            step("sparse");
            check_value("sparse.no_ch1_ch3", 32'(gnt & 4'b1010), 32'd0);
        end

        // Drain to idle, then a one-cycle request must still get a full dwell.
        req = 4'b0000;
        for (int i = 0; i < DW + 2 && m_ch >= 0; i++) step("drain");
        check_value("drain.idle_reached", (m_ch < 0) ? 32'd1 : 32'd0, 32'd1);
        req = 4'b0010;
        step("nonpre");
        req = 4'b0000;
        repeat (DW + 3) step("nonpre");

        // Reset during the second cycle of the ch2 dwell.
        rst_n = 1'b0; req = 4'b1111; en = 1'b1;
        step("midrst_pre");
        #2 rst_n = 1'b1;
        begin
            int found = 0;
            for (int i = 0; i < 40 && found == 0; i++) begin
                step("midrst_run");
                if (m_ch == 2 && m_left == DW - 1) found = 1;
            end
            check_value("midrst.reach_ch2", 32'(found), 32'd1);
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midrst_async");
        step("midrst_hold");
        #2 rst_n = 1'b1;
        step("midrst_after");
        check_value("midrst.first_gnt_ch0", 32'(gnt), 32'd1);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            req      = 4'($urandom_range(0, 15));
            en       = ($urandom_range(0, 7) != 0);
            mux_data = 4'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs("rand_rst");
                rst_n = 1'b1;
            end
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
